// File: rtl/pool_1_if.sv
// BRAM-side bundle of the pool_1 stage: conv1 result read port and pool1 result write port.
interface pool_1_if #(
  parameter int DATA_SIZE = 16
);
  logic [DATA_SIZE-1:0] input_bram_douta;
  logic                 input_bram_ena;
  logic [12:0]          input_bram_addra;
  logic                 result_bram_ena;
  logic                 result_bram_wea;
  logic [12:0]          result_bram_addra;
  logic [DATA_SIZE-1:0] result_bram_dina;

  // master is the pooling engine; slave is the memory side
  modport master (
    input  input_bram_douta,
    output input_bram_ena, input_bram_addra,
    output result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
  );
  modport slave (
    output input_bram_douta,
    input  input_bram_ena, input_bram_addra,
    input  result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
  );
endinterface

// File: rtl/pool_1.sv
// 2x2 stride-2 signed max pooling of the conv1 maps, sequenced by pool_1_en/pool_1_finish
// with 4-cycle BRAM accesses. All outputs are registered and freeze while pool_1_en is low.
module pool_1 #(
  parameter int DATA_SIZE = 16,
  parameter int IN_SIZE   = 28,
  parameter int OUT_SIZE  = 14,
  parameter int DEEP      = 6,
  parameter int IN_BASE   = 0,
  parameter int OUT_BASE  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pool_1_en,
  pool_1_if.master   bram,
  output logic       pool_1_finish,
  output logic [2:0] state_o
);
  localparam int CH_W = $clog2(DEEP + 1);
  localparam int RC_W = $clog2(OUT_SIZE);

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, COMPARE, STORE, DONE} state_e;

  state_e               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [RC_W-1:0]      r_q, r_d, c_q, c_d;
  logic [1:0]           k_q, k_d, circle_q, circle_d;
  logic [DATA_SIZE-1:0] max_q, max_d;
  logic                 in_ena_q, in_ena_d;
  logic [12:0]          in_addr_q, in_addr_d;
  logic                 res_ena_q, res_ena_d, res_we_q, res_we_d;
  logic [12:0]          res_addr_q, res_addr_d;
  logic [DATA_SIZE-1:0] res_din_q, res_din_d;
  logic                 finish_q, finish_d;
  logic [12:0]          rd_addr, wr_addr;

  // k[1] selects the window row (dy), k[0] the window column (dx)
  assign rd_addr = 13'(IN_BASE) + 13'(ch_q) * 13'(IN_SIZE * IN_SIZE)
                 + 13'({r_q, k_q[1]}) * 13'(IN_SIZE) + 13'({c_q, k_q[0]});
  assign wr_addr = 13'(OUT_BASE) + 13'(ch_q) * 13'(OUT_SIZE * OUT_SIZE)
                 + 13'(r_q) * 13'(OUT_SIZE) + 13'(c_q);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    r_d        = r_q;
    c_d        = c_q;
    k_d        = k_q;
    circle_d   = circle_q;
    max_d      = max_q;
    in_ena_d   = in_ena_q;
    in_addr_d  = in_addr_q;
    res_ena_d  = res_ena_q;
    res_we_d   = res_we_q;
    res_addr_d = res_addr_q;
    res_din_d  = res_din_q;
    finish_d   = finish_q;
    if (pool_1_en) begin
      case (state_q)
        IDLE: begin
          ch_d     = '0;
          r_d      = '0;
          c_d      = '0;
          max_d    = '0;
          finish_d = 1'b0;
          state_d  = CHECK;
        end
        CHECK: begin
          if (ch_q == CH_W'(DEEP)) begin
            in_ena_d  = 1'b0;
            res_ena_d = 1'b0;
            res_we_d  = 1'b0;
            finish_d  = 1'b1;
            state_d   = DONE;
          end else begin
            k_d      = '0;
            circle_d = '0;
            state_d  = LOAD;
          end
        end
        LOAD: begin
          circle_d = circle_q + 2'd1;
          if (circle_q == 2'd0) begin
            in_ena_d  = 1'b1;
            in_addr_d = rd_addr;
          end else if (circle_q == 2'd3) begin
            // strict compare so ties keep the earlier window element
            if (k_q == 2'd0 || $signed(bram.input_bram_douta) > $signed(max_q))
              max_d = bram.input_bram_douta;
            if (k_q == 2'd3) state_d = COMPARE;
            else             k_d = k_q + 2'd1;
          end
        end
        COMPARE: begin
          in_ena_d = 1'b0;
          circle_d = '0;
          state_d  = STORE;
        end
        STORE: begin
          circle_d = circle_q + 2'd1;
          if (circle_q == 2'd0) begin
            res_ena_d  = 1'b1;
            res_we_d   = 1'b1;
            res_addr_d = wr_addr;
            res_din_d  = max_q;
          end else if (circle_q == 2'd3) begin
            res_ena_d = 1'b0;
            res_we_d  = 1'b0;
            if (c_q == RC_W'(OUT_SIZE - 1)) begin
              c_d = '0;
              if (r_q == RC_W'(OUT_SIZE - 1)) begin
                r_d  = '0;
                ch_d = ch_q + CH_W'(1);
              end else begin
                r_d = r_q + RC_W'(1);
              end
            end else begin
              c_d = c_q + RC_W'(1);
            end
            state_d = CHECK;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end else if (state_q == DONE) begin
      // the controller acknowledges completion by dropping enable
      finish_d = 1'b0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      circle_q   <= '0;
      max_q      <= '0;
      in_ena_q   <= 1'b0;
      in_addr_q  <= '0;
      res_ena_q  <= 1'b0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_din_q  <= '0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      circle_q   <= circle_d;
      max_q      <= max_d;
      in_ena_q   <= in_ena_d;
      in_addr_q  <= in_addr_d;
      res_ena_q  <= res_ena_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      res_din_q  <= res_din_d;
      finish_q   <= finish_d;
    end
  end

  assign bram.input_bram_ena    = in_ena_q;
  assign bram.input_bram_addra  = in_addr_q;
  assign bram.result_bram_ena   = res_ena_q;
  assign bram.result_bram_wea   = res_we_q;
  assign bram.result_bram_addra = res_addr_q;
  assign bram.result_bram_dina  = res_din_q;
  assign pool_1_finish          = finish_q;
  assign state_o                = state_q;
endmodule

// File: tb/tb_pool_1.sv
// Bench for pool_1: BRAM models, expected-write queue with a monitor, directed layer runs
// covering ties/negatives, enable gaps, mid-layer reset and the finish handshake.
module tb_pool_1;
  localparam int NOUT = 1176;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd2, S_STORE = 3'd4;

  logic       clk = 1'b0;
  logic       rst, en, finish, clr_out;
  logic [2:0] dut_state;
  int         checks = 0, errors = 0, cyc = 0, wr_cnt = 0;
  int         t0, wr_base, took;
  logic       prev_we = 1'b0;

  logic [15:0] mem_in  [0:8191];
  logic [15:0] mem_out [0:8191];
  logic [28:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_1_if #(.DATA_SIZE(16)) bus ();

  pool_1 dut (
    .clk(clk), .rst(rst), .pool_1_en(en), .bram(bus.master),
    .pool_1_finish(finish), .state_o(dut_state)
  );

  always @(posedge clk) begin
    if (bus.input_bram_ena) bus.input_bram_douta <= mem_in[bus.input_bram_addra];
    if (clr_out) begin
      for (int i = 0; i < 8192; i++) mem_out[i] <= 16'hDEAD;
    end else if (bus.result_bram_ena && bus.result_bram_wea) begin
      mem_out[bus.result_bram_addra] <= bus.result_bram_dina;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] win_max(input int ch, input int r, input int c);
    int base;
    logic [15:0] m, v;
    base = ch * 784 + 2 * r * 28 + 2 * c;
    m = mem_in[base];
    for (int k = 1; k < 4; k++) begin
      v = mem_in[base + (k / 2) * 28 + (k % 2)];
      if ($signed(v) > $signed(m)) m = v;
    end
    return m;
  endfunction

  task automatic push_expected();
    exp_q.delete();
    for (int ch = 0; ch < 6; ch++)
      for (int r = 0; r < 14; r++)
        for (int c = 0; c < 14; c++)
          exp_q.push_back({13'(ch * 196 + r * 14 + c), win_max(ch, r, c)});
  endtask

  // monitor: one write transaction per rising edge of the result write enable
  always @(negedge clk) begin
    logic we_now;
    logic [28:0] e;
    we_now = bus.result_bram_ena && bus.result_bram_wea;
    if (!rst && we_now && !prev_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got write at %0d, expected none", bus.result_bram_addra);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.result_bram_addra), 32'(e[28:16]));
        check("wr_data", 32'(bus.result_bram_dina), 32'(e[15:0]));
      end
    end
    prev_we = rst ? 1'b0 : we_now;
  end

  task automatic check_reset_outputs();
    check("rst_state", 32'(dut_state), 32'(S_IDLE));
    check("rst_in_ena", 32'(bus.input_bram_ena), 0);
    check("rst_in_addr", 32'(bus.input_bram_addra), 0);
    check("rst_res_ena", 32'(bus.result_bram_ena), 0);
    check("rst_res_wea", 32'(bus.result_bram_wea), 0);
    check("rst_res_addr", 32'(bus.result_bram_addra), 0);
    check("rst_res_din", 32'(bus.result_bram_dina), 0);
    check("rst_finish", 32'(finish), 0);
  endtask

  task automatic wait_state(input logic [2:0] s, input bit want_ena, input string name);
    int n = 0;
    while (!(dut_state == s && (want_ena ? (bus.input_bram_ena | bus.result_bram_ena) : 1'b1))
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached"}, 32'(dut_state), 32'(s));
  endtask

  task automatic en_gap(input string name);
    logic [49:0] snap;
    int bad = 0;
    en = 1'b0;
    snap = {dut_state, finish, bus.input_bram_ena, bus.input_bram_addra, bus.result_bram_ena,
            bus.result_bram_wea, bus.result_bram_addra, bus.result_bram_dina};
    repeat (10) begin
      @(negedge clk);
      if ({dut_state, finish, bus.input_bram_ena, bus.input_bram_addra, bus.result_bram_ena,
           bus.result_bram_wea, bus.result_bram_addra, bus.result_bram_dina} !== snap) bad++;
    end
    check({name, "_hold_violations"}, 32'(bad), 0);
    en = 1'b1;
  endtask

  task automatic wait_finish(input int budget, output int n);
    n = 0;
    while (!finish && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("finish_seen", 32'(finish), 1);
  endtask

  task automatic check_final_mem(input string name);
    int bad = 0;
    for (int ch = 0; ch < 6; ch++)
      for (int r = 0; r < 14; r++)
        for (int c = 0; c < 14; c++)
          if (mem_out[ch * 196 + r * 14 + c] !== win_max(ch, r, c)) bad++;
    check({name, "_bad_words"}, 32'(bad), 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 8192; i++) mem_in[i] = (i < 4704) ? 16'(i) : 16'h0;
  endtask

  task automatic release_run();
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    t0 = cyc;
    wr_base = wr_cnt;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    clr_out = 1'b1;
    load_ramp();
    // tie, ordering and signed windows at outputs 0,1,2 of channel 0
    mem_in[0] = 16'd5;    mem_in[1] = 16'd5;    mem_in[28] = 16'd5;   mem_in[29] = 16'd5;
    mem_in[2] = 16'd7;    mem_in[3] = 16'hFFFD; mem_in[30] = 16'd9;   mem_in[31] = 16'd9;
    mem_in[4] = 16'hFFF0; mem_in[5] = 16'hFF00; mem_in[32] = 16'h8000; mem_in[33] = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr_out = 1'b0;
    check_reset_outputs();

    // run 1: special windows, enable gaps in LOAD and STORE
    push_expected();
    release_run();
    repeat (100) @(negedge clk);
    wait_state(S_LOAD, 1'b1, "gap_load");
    en_gap("gap_load");
    repeat (50) @(negedge clk);
    wait_state(S_STORE, 1'b1, "gap_store");
    en_gap("gap_store");
    wait_finish(30000, took);
    check("run1_finish_cycle", 32'(cyc - t0), 32'(25894));
    check("run1_write_count", 32'(wr_cnt - wr_base), NOUT);
    check("run1_queue_left", 32'(exp_q.size()), 0);
    check("run1_out0_tie", 32'(mem_out[0]), 32'd5);
    check("run1_out1_order", 32'(mem_out[1]), 32'd9);
    check("run1_out2_signed", 32'(mem_out[2]), 32'hFFFF);
    check("run1_out3_ramp", 32'(mem_out[3]), 32'd35);
    check("run1_out1175", 32'(mem_out[1175]), 32'd4703);
    check_final_mem("run1_mem");
    en = 1'b0;
    @(negedge clk);
    check("run1_finish_clear", 32'(finish), 0);

    // run 2: plain ramp, reset after write #300, then a full rerun
    rst = 1'b1;
    load_ramp();
    @(negedge clk);
    push_expected();
    release_run();
    took = 0;
    while ((wr_cnt - wr_base) < 300 && took < 10000) begin
      @(negedge clk);
      took++;
    end
    check("run2_reached_300", 32'(wr_cnt - wr_base), 300);
    while (bus.result_bram_ena && took < 10000) begin
      @(negedge clk);
      took++;
    end
    rst = 1'b1;
    clr_out = 1'b1;
    @(negedge clk);
    clr_out = 1'b0;
    check_reset_outputs();
    push_expected();
    release_run();
    wait_finish(30000, took);
    check("run2_finish_cycle", 32'(cyc - t0), 32'(25874));
    check("run2_write_count", 32'(wr_cnt - wr_base), NOUT);
    check("run2_queue_left", 32'(exp_q.size()), 0);
    check("run2_out0", 32'(mem_out[0]), 32'd29);
    check("run2_out1175", 32'(mem_out[1175]), 32'd4703);
    check_final_mem("run2_mem");

    // finish held with en high, no BRAM activity
    repeat (50) begin
      @(negedge clk);
      check("done_finish_held", 32'(finish), 1);
      check("done_no_bram", 32'({bus.input_bram_ena, bus.result_bram_ena, bus.result_bram_wea}), 0);
    end
    en = 1'b0;
    @(negedge clk);
    check("done_finish_clear", 32'(finish), 0);
    check("done_back_idle", 32'(dut_state), 32'(S_IDLE));
    en = 1'b1;
    took = 0;
    while (!bus.input_bram_ena && took < 10) begin
      @(negedge clk);
      took++;
    end
    check("rerun_read_ena", 32'(bus.input_bram_ena), 1);
    check("rerun_first_addr", 32'(bus.input_bram_addra), 0);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
